// File: rtl/falafel_lsu.sv
// Falafel allocator load/store unit: turns header_req_t operations into single-beat
// 64-bit memory transactions on a req/gnt/rvalid port, one operation at a time.
package falafel_pkg;
  localparam logic [63:0] EMPTY_KEY              = '0;
  localparam logic [63:0] BLOCK_NEXT_ADDR_OFFSET = 64'd8;

  typedef enum logic [2:0] {
    LSU_NOP                     = 3'd0,
    LSU_LOCK                    = 3'd1,
    LSU_UNLOCK                  = 3'd2,
    LSU_LOAD                    = 3'd3,
    LSU_EDIT_SIZE_AND_NEXT_ADDR = 3'd4,
    LSU_EDIT_NEXT_ADDR          = 3'd5
  } lsu_op_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] size;
    logic [63:0] next_addr;
  } header_t;

  typedef struct packed {
    header_t header;
    logic    val;
    lsu_op_t lsu_op;
  } header_req_t;

  typedef struct packed {
    header_t header;
    logic    val;
  } header_rsp_t;
endpackage

module falafel_lsu
  import falafel_pkg::*;
#(
  parameter logic [63:0] LOCK_ADDR    = 64'h1000,
  parameter int unsigned LOCK_BACKOFF = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  header_req_t req_i,
  output logic        req_ready_o,
  output header_rsp_t rsp_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_LK_RD, S_LK_RWAIT, S_LK_BO, S_LK_WR,
    S_RD_SZ, S_RD_SZ_W, S_RD_NX, S_RD_NX_W, S_WR_SZ, S_WR_NX, S_RSP
  } state_t;

  localparam logic [31:0] BO_LAST = (LOCK_BACKOFF == 0) ? 32'd0 : 32'(LOCK_BACKOFF - 1);

  state_t      r_state, w_next;
  header_t     r_hdr, r_rsp_hdr;
  lsu_op_t     r_op;
  logic [31:0] r_bo_cnt;
  logic        w_accept, w_bo_done;
  logic [63:0] w_addr_nx;

  assign w_accept  = (r_state == S_IDLE) && req_i.val;
  assign w_bo_done = (r_bo_cnt == BO_LAST);
  assign w_addr_nx = r_hdr.addr + BLOCK_NEXT_ADDR_OFFSET;

  always_comb begin
    w_next      = r_state;
    req_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_i.val) begin
          case (req_i.lsu_op)
            LSU_LOCK:                    w_next = S_LK_RD;
            LSU_UNLOCK:                  w_next = S_LK_WR;
            LSU_LOAD:                    w_next = (req_i.header.addr == EMPTY_KEY) ? S_RSP : S_RD_SZ;
            LSU_EDIT_SIZE_AND_NEXT_ADDR: w_next = S_WR_SZ;
            LSU_EDIT_NEXT_ADDR:          w_next = S_WR_NX;
            default:                     w_next = S_RSP;
          endcase
        end
      end
      S_LK_RD: begin
        mem_req_o  = 1'b1;
        mem_addr_o = LOCK_ADDR;
        if (mem_gnt_i) w_next = S_LK_RWAIT;
      end
      S_LK_RWAIT: begin
        if (mem_rvalid_i) begin
          if (mem_rdata_i == '0)      w_next = S_LK_WR;
          else if (LOCK_BACKOFF == 0) w_next = S_LK_RD;
          else                        w_next = S_LK_BO;
        end
      end
      S_LK_BO: begin
        if (w_bo_done) w_next = S_LK_RD;
      end
      S_LK_WR: begin
        // Shared by LOCK (take: write 1) and UNLOCK (release: write 0).
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = LOCK_ADDR;
        mem_wdata_o = (r_op == LSU_LOCK) ? 64'd1 : 64'd0;
        if (mem_gnt_i) w_next = S_RSP;
      end
      S_RD_SZ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = r_hdr.addr;
        if (mem_gnt_i) w_next = S_RD_SZ_W;
      end
      S_RD_SZ_W: begin
        if (mem_rvalid_i) w_next = S_RD_NX;
      end
      S_RD_NX: begin
        mem_req_o  = 1'b1;
        mem_addr_o = w_addr_nx;
        if (mem_gnt_i) w_next = S_RD_NX_W;
      end
      S_RD_NX_W: begin
        if (mem_rvalid_i) w_next = S_RSP;
      end
      S_WR_SZ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = r_hdr.addr;
        mem_wdata_o = r_hdr.size;
        if (mem_gnt_i) w_next = S_WR_NX;
      end
      S_WR_NX: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = w_addr_nx;
        mem_wdata_o = r_hdr.next_addr;
        if (mem_gnt_i) w_next = S_RSP;
      end
      S_RSP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The live header is shown during the pulse; afterwards the latched copy holds it.
  always_comb begin
    rsp_o        = '0;
    rsp_o.val    = (r_state == S_RSP);
    rsp_o.header = (r_state == S_RSP) ? r_hdr : r_rsp_hdr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_hdr     <= '0;
      r_rsp_hdr <= '0;
      r_op      <= LSU_NOP;
      r_bo_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_hdr <= req_i.header;
        r_op  <= req_i.lsu_op;
        if (req_i.lsu_op == LSU_LOAD && req_i.header.addr == EMPTY_KEY) begin
          r_hdr.size      <= '0;
          r_hdr.next_addr <= '0;
        end
      end
      if (r_state == S_RD_SZ_W && mem_rvalid_i) r_hdr.size      <= mem_rdata_i;
      if (r_state == S_RD_NX_W && mem_rvalid_i) r_hdr.next_addr <= mem_rdata_i;
      if (r_state == S_RSP) r_rsp_hdr <= r_hdr;
      if (r_state == S_LK_BO) r_bo_cnt <= w_bo_done ? '0 : r_bo_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_falafel_lsu.sv
// Self-checking bench for falafel_lsu: directed vector table, hand-written corner
// sequences and randomized operations checked against a transaction-level model.
module tb_falafel_lsu;
  import falafel_pkg::*;

  localparam logic [63:0] LOCK_A = 64'h1000;
  localparam int          BO     = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  header_req_t req;
  header_rsp_t rsp;
  logic        ready, mreq, mwe;
  logic        mgnt = 1'b0, mrv = 1'b0;
  logic [63:0] maddr, mwd;
  logic [63:0] mrd = '0;

  always #5 clk = ~clk;

  falafel_lsu #(.LOCK_ADDR(LOCK_A), .LOCK_BACKOFF(BO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .req_ready_o(ready), .rsp_o(rsp),
    .mem_req_o(mreq), .mem_gnt_i(mgnt), .mem_we_o(mwe), .mem_addr_o(maddr),
    .mem_wdata_o(mwd), .mem_rvalid_i(mrv), .mem_rdata_i(mrd)
  );

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } txn_t;

  txn_t        log_q[$];
  txn_t        exp_q[$];
  logic [63:0] mem [logic [63:0]];
  int nvec = 0, nfail = 0, cyc = 0, accepts = 0, rsp_pulses = 0;
  int gdelay = 0, rvdelay = 1, lock_fails = 0, stall = 0, rv_cnt = 0;
  bit          rd_pend = 0, prev_stalled = 0, st_we = 0;
  logic [63:0] rd_data = '0, st_addr = '0, st_wd = '0;

  // Memory responder: transfers on the rising edge, drives gnt/rvalid on the falling edge.
  always @(posedge clk) begin
    txn_t t;
    cyc++;
    if (ready && req.val) accepts++;
    if (mreq && mgnt) begin
      t.we   = mwe;
      t.addr = maddr;
      t.cyc  = cyc;
      if (mwe) begin
        t.data     = mwd;
        mem[maddr] = mwd;
      end else begin
        if (maddr == LOCK_A) begin
          t.data = (lock_fails > 0) ? 64'd1 : 64'd0;
          if (lock_fails > 0) lock_fails--;
        end else begin
          t.data = mem.exists(maddr) ? mem[maddr] : 64'd0;
        end
        rd_pend = 1;
        rv_cnt  = rvdelay;
        rd_data = t.data;
      end
      log_q.push_back(t);
    end
  end

  always @(negedge clk) begin
    mrv = 1'b0;
    if (rd_pend) begin
      if (rv_cnt <= 1) begin
        mrv = 1'b1; mrd = rd_data; rd_pend = 0;
      end else rv_cnt--;
    end
    if (rsp.val) rsp_pulses++;
    if (rst_n && prev_stalled) begin
      nvec++;
      if (!(mreq && maddr == st_addr && mwe == st_we && mwd == st_wd)) begin
        nfail++;
        $display("FAIL stall_stable: got req=%0b addr=%h we=%0b wdata=%h required req=1 addr=%h we=%0b wdata=%h",
                 mreq, maddr, mwe, mwd, st_addr, st_we, st_wd);
      end
    end
    mgnt = mreq && (stall >= gdelay);
    if (mreq && !mgnt) stall++; else stall = 0;
    prev_stalled = mreq && !mgnt;
    st_addr = maddr; st_we = mwe; st_wd = mwd;
  end

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic chkh(input string nm, input header_t act, input header_t exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got {%h,%h,%h} required {%h,%h,%h}", nm,
               act.addr, act.size, act.next_addr, exp.addr, exp.size, exp.next_addr);
    end
  endtask

  task automatic chk_txns(input string nm);
    bit bad;
    bad = (log_q.size() != exp_q.size());
    for (int j = 0; j < exp_q.size() && !bad; j++)
      if (log_q[j].we != exp_q[j].we || log_q[j].addr !== exp_q[j].addr ||
          log_q[j].data !== exp_q[j].data) bad = 1;
    nvec++;
    if (bad) begin
      nfail++;
      $display("FAIL %s: got %0d transactions required %0d (or contents differ)",
               nm, log_q.size(), exp_q.size());
    end
  endtask

  // Called at a falling edge; returns at the falling edge where the response is seen.
  task automatic do_op(input lsu_op_t op, input header_t h, input int g, input int rv, input int nf,
                       output header_t rh, output int lat, output bit got);
    int k;
    gdelay = g; rvdelay = rv; lock_fails = nf;
    log_q.delete();
    got = 0; lat = 0; rh = '0;
    k = 0;
    while (!ready && k < 50) begin @(negedge clk); k++; end
    req.header = h; req.lsu_op = op; req.val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req.val = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      if (i > 1) @(negedge clk);
      if (rsp.val) begin
        got = 1; lat = i; rh = rsp.header;
        break;
      end
    end
  endtask

  function automatic logic [63:0] peek(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 64'd0;
  endfunction

  function automatic void push(input bit we, input logic [63:0] a, input logic [63:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d; t.cyc = 0;
    exp_q.push_back(t);
  endfunction

  // Reference: each write costs g+1 cycles, each read g+1+rv, each lock retry BO more, +1 response.
  function automatic void model(input lsu_op_t op, input header_t h, input int g, input int rv,
                                input int nf, output header_t eh, output int elat);
    exp_q.delete();
    eh = h;
    elat = 1;
    case (op)
      LSU_LOAD: begin
        if (h.addr == 64'd0) begin
          eh.size = '0; eh.next_addr = '0;
        end else begin
          eh.size      = peek(h.addr);
          eh.next_addr = peek(h.addr + 64'd8);
          push(0, h.addr, eh.size);
          push(0, h.addr + 64'd8, eh.next_addr);
          elat = 2 * (g + 1 + rv) + 1;
        end
      end
      LSU_EDIT_SIZE_AND_NEXT_ADDR: begin
        push(1, h.addr, h.size);
        push(1, h.addr + 64'd8, h.next_addr);
        elat = 2 * (g + 1) + 1;
      end
      LSU_EDIT_NEXT_ADDR: begin
        push(1, h.addr + 64'd8, h.next_addr);
        elat = g + 2;
      end
      LSU_UNLOCK: begin
        push(1, LOCK_A, 64'd0);
        elat = g + 2;
      end
      LSU_LOCK: begin
        for (int i = 0; i < nf; i++) push(0, LOCK_A, 64'd1);
        push(0, LOCK_A, 64'd0);
        push(1, LOCK_A, 64'd1);
        elat = (nf + 1) * (g + 1 + rv) + nf * BO + (g + 1) + 1;
      end
      default: elat = 1;
    endcase
  endfunction

  typedef struct {
    lsu_op_t     op;
    logic [63:0] addr, size, nxt;
    int          g, rv, nf;
    logic [63:0] m0, m1;
    int          e_lat;
    logic [63:0] e_size, e_next;
    int          e_ntxn;
    logic [63:0] e_last_addr, e_last_data;
  } vec_t;

  initial begin : main
    vec_t        tv[10];
    header_t     h, rh, eh;
    int          lat, elat, nops, acc0, pul0, k;
    bit          got;
    logic [63:0] pool[4];
    lsu_op_t     op;

    nops = 0;
    req = '0;
    tv[0] = '{LSU_LOAD, 64'h2000, 64'h0, 64'h0, 0, 1, 0, 64'h40, 64'h3000, 5, 64'h40, 64'h3000, 2, 64'h2008, 64'h3000};
    tv[1] = '{LSU_LOAD, 64'h0, 64'h77, 64'h88, 0, 1, 0, 64'h0, 64'h0, 1, 64'h0, 64'h0, 0, 64'h0, 64'h0};
    tv[2] = '{LSU_EDIT_SIZE_AND_NEXT_ADDR, 64'h2000, 64'h20, 64'h2020, 3, 1, 0, 64'h0, 64'h0, 9, 64'h20, 64'h2020, 2, 64'h2008, 64'h2020};
    tv[3] = '{LSU_EDIT_NEXT_ADDR, 64'hFFFF_FFFF_FFFF_FFF8, 64'h5, 64'h1234, 0, 1, 0, 64'h0, 64'h0, 2, 64'h5, 64'h1234, 1, 64'h0, 64'h1234};
    tv[4] = '{LSU_UNLOCK, 64'h10, 64'h0, 64'h0, 0, 1, 0, 64'h0, 64'h0, 2, 64'h0, 64'h0, 1, 64'h1000, 64'h0};
    tv[5] = '{LSU_LOCK, 64'h18, 64'h1, 64'h2, 0, 1, 0, 64'h0, 64'h0, 4, 64'h1, 64'h2, 2, 64'h1000, 64'h1};
    tv[6] = '{lsu_op_t'(3'd7), 64'h3000, 64'h1, 64'h2, 0, 1, 0, 64'h0, 64'h0, 1, 64'h1, 64'h2, 0, 64'h0, 64'h0};
    tv[7] = '{LSU_LOAD, 64'h4000, 64'h0, 64'h0, 2, 2, 0, 64'hAA, 64'hBB, 11, 64'hAA, 64'hBB, 2, 64'h4008, 64'hBB};
    tv[8] = '{LSU_EDIT_NEXT_ADDR, 64'h5000, 64'h3, 64'h99, 1, 1, 0, 64'h0, 64'h0, 3, 64'h3, 64'h99, 1, 64'h5008, 64'h99};
    tv[9] = '{LSU_LOAD, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 0, 1, 0, 64'h10, 64'h20, 5, 64'h10, 64'h20, 2, 64'h0, 64'h20};

    repeat (3) @(negedge clk);
    chk64("in_reset_mem_addr", maddr, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chki("rst_ready", int'(ready), 1);
    chki("rst_rsp_val", int'(rsp.val), 0);
    chkh("rst_rsp_hdr", rsp.header, '0);
    chki("rst_mem_req", int'(mreq), 0);
    chki("rst_mem_we", int'(mwe), 0);
    chk64("rst_mem_addr", maddr, 64'h0);
    chk64("rst_mem_wdata", mwd, 64'h0);

    // Directed vector table.
    for (int v = 0; v < 10; v++) begin
      if (tv[v].op == LSU_LOAD && tv[v].addr != 64'd0) begin
        mem[tv[v].addr] = tv[v].m0;
        mem[tv[v].addr + 64'd8] = tv[v].m1;
      end
      h.addr = tv[v].addr; h.size = tv[v].size; h.next_addr = tv[v].nxt;
      do_op(tv[v].op, h, tv[v].g, tv[v].rv, tv[v].nf, rh, lat, got);
      nops++;
      chki($sformatf("vec%0d_rsp_seen", v), int'(got), 1);
      chki($sformatf("vec%0d_latency", v), lat, tv[v].e_lat);
      chk64($sformatf("vec%0d_rsp_addr", v), rh.addr, tv[v].addr);
      chk64($sformatf("vec%0d_rsp_size", v), rh.size, tv[v].e_size);
      chk64($sformatf("vec%0d_rsp_next", v), rh.next_addr, tv[v].e_next);
      chki($sformatf("vec%0d_ntxn", v), log_q.size(), tv[v].e_ntxn);
      if (tv[v].e_ntxn > 0 && log_q.size() > 0) begin
        chk64($sformatf("vec%0d_last_addr", v), log_q[log_q.size()-1].addr, tv[v].e_last_addr);
        chk64($sformatf("vec%0d_last_data", v), log_q[log_q.size()-1].data, tv[v].e_last_data);
      end
    end

    // Contended lock: two busy reads, backoff spacing, then take and release.
    h = '{64'h100, 64'h0, 64'h0};
    do_op(LSU_LOCK, h, 0, 1, 2, rh, lat, got);
    nops++;
    chki("lock_busy_latency", lat, 16);
    chki("lock_busy_ntxn", log_q.size(), 4);
    if (log_q.size() == 4) begin
      chki("lock_gap_1", log_q[1].cyc - log_q[0].cyc, 2 + BO);
      chki("lock_gap_2", log_q[2].cyc - log_q[1].cyc, 2 + BO);
      chki("lock_take_we", int'(log_q[3].we), 1);
      chk64("lock_take_data", log_q[3].data, 64'h1);
    end
    do_op(LSU_UNLOCK, h, 0, 1, 0, rh, lat, got);
    nops++;
    chki("unlock_latency", lat, 2);
    chk64("unlock_data", (log_q.size() == 1) ? log_q[0].data : 64'hDEAD, 64'h0);

    // Request held high while busy: exactly one accept.
    mem[64'h2000] = 64'h40; mem[64'h2008] = 64'h3000;
    gdelay = 1; rvdelay = 1;
    k = 0;
    while (!ready && k < 50) begin @(negedge clk); k++; end
    acc0 = accepts;
    req.header = '{64'h2000, 64'h0, 64'h0}; req.lsu_op = LSU_LOAD; req.val = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rsp.val) begin got = 1; rh = rsp.header; end
    end
    req.val = 1'b0;
    nops++;
    chki("held_val_accepts", accepts - acc0, 1);
    chkh("held_val_rsp", rh, '{64'h2000, 64'h40, 64'h3000});

    // Reset while waiting for the second load beat.
    @(negedge clk);
    gdelay = 0; rvdelay = 4; log_q.delete();
    req.header = '{64'h2000, 64'h0, 64'h0}; req.lsu_op = LSU_LOAD; req.val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req.val = 1'b0;
    k = 0;
    while (log_q.size() < 2 && k < 50) begin @(negedge clk); k++; end
    chki("reset_reached_rd_nx_w", log_q.size(), 2);
    rst_n = 1'b0;
    #1;
    chki("reset_mem_req", int'(mreq), 0);
    chki("reset_mem_we", int'(mwe), 0);
    chk64("reset_mem_addr", maddr, 64'h0);
    chk64("reset_mem_wdata", mwd, 64'h0);
    chki("reset_rsp_val", int'(rsp.val), 0);
    chkh("reset_rsp_hdr", rsp.header, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pul0 = rsp_pulses;
    repeat (10) @(negedge clk);
    chki("no_rsp_after_reset", rsp_pulses - pul0, 0);
    chki("ready_after_reset", int'(ready), 1);

    // Randomized operations against the transaction-level model.
    pool[0] = 64'h2000; pool[1] = 64'h2010; pool[2] = 64'h0; pool[3] = 64'hFFFF_FFFF_FFFF_FFF8;
    for (int r = 0; r < 60; r++) begin
      int g, rv, nf;
      op = lsu_op_t'(3'($urandom_range(0, 7)));
      g  = $urandom_range(0, 3);
      rv = $urandom_range(1, 3);
      nf = (op == LSU_LOCK) ? $urandom_range(0, 2) : 0;
      if ($urandom_range(0, 2) == 0) h.addr = {$urandom, $urandom} & ~64'h7;
      else h.addr = pool[$urandom_range(0, 3)];
      h.size = {$urandom, $urandom};
      h.next_addr = {$urandom, $urandom};
      if (op == LSU_LOAD && $urandom_range(0, 1) == 0) begin
        mem[h.addr] = {$urandom, $urandom};
        mem[h.addr + 64'd8] = {$urandom, $urandom};
      end
      model(op, h, g, rv, nf, eh, elat);
      do_op(op, h, g, rv, nf, rh, lat, got);
      nops++;
      chki($sformatf("rnd%0d_rsp_seen", r), int'(got), 1);
      chki($sformatf("rnd%0d_latency op=%0d", r, op), lat, elat);
      chkh($sformatf("rnd%0d_rsp_hdr op=%0d", r, op), rh, eh);
      chk_txns($sformatf("rnd%0d_txns op=%0d", r, op));
    end

    repeat (3) @(negedge clk);
    chki("total_rsp_pulses", rsp_pulses, nops);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    nfail++;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $fatal(1);
  end

endmodule
